rans_bit_packer: RTL and testbench

- Downstream of the rANS encoder core. Consumes the variable-length renormalisation chunks the encoder emits as an enc/enc_len pair.
- Packs the chunks LSB-first into fixed-width words for the output stream buffer.
- A flush request drains all residual bits. The final, possibly partial, word is tagged with out_last and its valid bit count.

---
 rtl/rans_bit_packer.sv | 132 +++++++++++++
 tb/tb_rans_bit_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_bit_packer.sv
// Packs variable-length rANS renormalisation chunks LSB-first into fixed-width words.
// A flush drains residual bits into one final word tagged with out_last and its bit count.
module rans_bit_packer #(
  parameter int CHUNK_WIDTH     = 16,
  parameter int CHUNK_LEN_WIDTH = 5,
  parameter int WORD_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHUNK_WIDTH-1:0]         in_data,
  input  logic [CHUNK_LEN_WIDTH-1:0]     in_len,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORD_WIDTH-1:0]          out_data,
  output logic [$clog2(WORD_WIDTH+1)-1:0] out_nbits,
  output logic                           out_last,
  output logic                           busy
);

  localparam int ACC_W  = WORD_WIDTH + CHUNK_WIDTH;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NB_W   = $clog2(WORD_WIDTH + 1);
  localparam logic [FILL_W-1:0]          WW_F = FILL_W'(WORD_WIDTH);
  localparam logic [CHUNK_LEN_WIDTH-1:0] CW_L = CHUNK_LEN_WIDTH'(CHUNK_WIDTH);

  typedef enum logic [1:0] {PACK, FLUSH, LAST} state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
  logic [NB_W-1:0]        out_nbits_q, out_nbits_d;
  logic                   out_last_q, out_last_d;

  logic [CHUNK_LEN_WIDTH-1:0] len_c;
  logic [CHUNK_WIDTH-1:0]     chunk_bits;
  logic                       word_ready;
  logic                       out_free;
  logic                       accept;

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready   = (state_q == PACK) && (fill_q < WW_F);
  assign len_c      = (in_len > CW_L) ? CW_L : in_len;
  assign chunk_bits = in_data & ~({CHUNK_WIDTH{1'b1}} << len_c);
  assign word_ready = (fill_q >= WW_F);
  assign out_free   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A full word moves out in PACK and FLUSH alike; fill is always zero in LAST.
    if (word_ready && out_free) begin
      out_data_d  = acc_q[WORD_WIDTH-1:0];
      out_nbits_d = NB_W'(WORD_WIDTH);
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      acc_d       = acc_q >> WORD_WIDTH;
      fill_d      = fill_q - WW_F;
    end

    case (state_q)
      PACK: begin
        if (accept) begin
          acc_d  = acc_q | ({{WORD_WIDTH{1'b0}}, chunk_bits} << fill_q);
          fill_d = fill_q + FILL_W'(len_c);
        end
        if (in_ready && flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!word_ready && out_free) begin
          out_data_d  = acc_q[WORD_WIDTH-1:0] & ~({WORD_WIDTH{1'b1}} << fill_q);
          out_nbits_d = NB_W'(fill_q);
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          acc_d       = '0;
          fill_d      = '0;
          state_d     = LAST;
        end
      end
      LAST: begin
        if (out_valid_q && out_ready) begin
          state_d = PACK;
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PACK;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nbits = out_nbits_q;
  assign out_last  = out_last_q;
  assign busy      = (fill_q != '0) || out_valid_q || (state_q != PACK);

endmodule

// File: tb/tb_rans_bit_packer.sv
// Directed and reference-queue checks for rans_bit_packer; inputs driven and outputs sampled on negedge.
module tb_rans_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_nbits;
  logic        out_last;
  logic        busy;

  int passed = 0;
  int total  = 0;

  rans_bit_packer #(.CHUNK_WIDTH(16), .CHUNK_LEN_WIDTH(5), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_len = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one chunk/flush until in_ready, then holds it across one accepting edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] l, input logic f);
    int n = 0;
    in_valid = v; in_data = d; in_len = l; flush = f;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL drive_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, out_last, out_nbits, out_data, in_ready, busy} !== {1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: valid=%0b last=%0b nbits=%0d data=%h in_ready=%0b busy=%0b, required 0 0 0 0 1 0",
               out_valid, out_last, out_nbits, out_data, in_ready, busy);
    end else passed++;
  endtask

  task automatic test_pack_word();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h0001, 5'd1, 1'b0);
    drive(1'b1, 16'h0002, 5'd2, 1'b0);
    drive(1'b1, 16'h0ABC, 5'd12, 1'b0);
    drive(1'b1, 16'h1234, 5'd16, 1'b0);
    total++;
    if (dut.fill_q !== 6'd31) begin
      $display("FAIL pack_fill31: fill=%0d, required 31", dut.fill_q);
    end else passed++;
    drive(1'b1, 16'h0005, 5'd4, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL pack_latency: out_valid=%0b one cycle after completing accept, required 0", out_valid);
    end else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_nbits, out_data} !== {1'b1, 1'b0, 6'd32, 32'h891A55E5}) begin
      $display("FAIL pack_word: valid=%0b last=%0b nbits=%0d data=%h, required 1 0 32 891a55e5",
               out_valid, out_last, out_nbits, out_data);
    end else passed++;
    total++;
    if (dut.fill_q !== 6'd3) begin
      $display("FAIL pack_residual: fill=%0d, required 3", dut.fill_q);
    end else passed++;
  endtask

  task automatic test_flush_with_chunk();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'hBEEF, 5'd16, 1'b0);
    drive(1'b1, 16'hDEAD, 5'd16, 1'b1);
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_nbits, out_data} !== {1'b1, 1'b0, 6'd32, 32'hDEADBEEF}) begin
      $display("FAIL flush_full_word: valid=%0b last=%0b nbits=%0d data=%h, required 1 0 32 deadbeef",
               out_valid, out_last, out_nbits, out_data);
    end else passed++;
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_nbits, out_data} !== {1'b1, 1'b1, 6'd0, 32'h0}) begin
      $display("FAIL flush_empty_last: valid=%0b last=%0b nbits=%0d data=%h, required 1 1 0 0",
               out_valid, out_last, out_nbits, out_data);
    end else passed++;
    @(negedge clk);
    total++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      $display("FAIL flush_idle: busy=%0b out_valid=%0b in_ready=%0b, required 0 0 1", busy, out_valid, in_ready);
    end else passed++;
  endtask

  task automatic test_last_backpressure();
    int bad = 0;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 16'h0005, 5'd3, 1'b0);
    drive(1'b0, 16'h0000, 5'd0, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      if ({out_valid, out_last, out_nbits, out_data, in_ready} !== {1'b1, 1'b1, 6'd3, 32'h5, 1'b0}) bad++;
      @(negedge clk);
    end
    total++;
    if (bad != 0) begin
      $display("FAIL last_hold: %0d of 5 stalled cycles deviated, required 0 (valid=%0b last=%0b nbits=%0d data=%h)",
               bad, out_valid, out_last, out_nbits, out_data);
    end else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      $display("FAIL last_retire: out_valid=%0b in_ready=%0b busy=%0b, required 0 1 0", out_valid, in_ready, busy);
    end else passed++;
  endtask

  task automatic test_random_stream();
    bit q[$];
    int bad_bits = 0, ready_bad = 0, words = 0, cyc = 0;
    bit done = 1'b0;
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          logic [15:0] d;
          logic [4:0]  l;
          int n;
          d = 16'($urandom);
          l = 5'($urandom_range(0, 16));
          in_valid = 1'b1; in_data = d; in_len = l; flush = 1'b0;
          n = 0;
          while (n < 200) begin
            if (in_ready !== (dut.fill_q < 6'd32)) ready_bad++;
            if (in_ready) break;
            @(negedge clk);
            n++;
          end
          for (int b = 0; b < int'(l); b++) q.push_back(d[b]);
          @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b1;
        while (!in_ready && cyc < 20000) @(negedge clk);
        @(negedge clk);
        flush = 1'b0;
      end
      begin
        while (!done && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = ~out_ready;
          if (out_valid && out_ready) begin
            for (int b = 0; b < int'(out_nbits); b++) begin
              if (q.size() == 0) bad_bits++;
              else if (q.pop_front() !== out_data[b]) bad_bits++;
            end
            words++;
            if (out_last) done = 1'b1;
          end
        end
      end
    join
    @(negedge clk);
    total++;
    if (!done) begin
      $display("FAIL stream_timeout: out_last seen=%0b after %0d cycles, required 1", done, cyc);
    end else passed++;
    total++;
    if (bad_bits != 0) begin
      $display("FAIL stream_bits: %0d mismatching bits over %0d words, required 0", bad_bits, words);
    end else passed++;
    total++;
    if (q.size() != 0) begin
      $display("FAIL stream_residual: %0d reference bits never emitted, required 0", q.size());
    end else passed++;
    total++;
    if (ready_bad != 0) begin
      $display("FAIL stream_in_ready: %0d cycles where in_ready disagreed with fill<32, required 0", ready_bad);
    end else passed++;
  endtask

  task automatic test_len_edges();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 5'd4, 1'b0);
    total++;
    if (dut.fill_q !== 6'd4) begin
      $display("FAIL len4_fill: fill=%0d, required 4", dut.fill_q);
    end else passed++;
    drive(1'b1, 16'h1234, 5'd0, 1'b0);
    total++;
    if (dut.fill_q !== 6'd4) begin
      $display("FAIL len0_fill: fill=%0d, required 4", dut.fill_q);
    end else passed++;
    drive(1'b1, 16'hFFFF, 5'd20, 1'b0);
    total++;
    if (dut.fill_q !== 6'd20) begin
      $display("FAIL len20_clamp: fill=%0d, required 20", dut.fill_q);
    end else passed++;
    drive(1'b0, 16'h0000, 5'd0, 1'b1);
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_nbits, out_data} !== {1'b1, 1'b1, 6'd20, 32'h000FFFFF}) begin
      $display("FAIL len_edges_word: valid=%0b last=%0b nbits=%0d data=%h, required 1 1 20 000fffff",
               out_valid, out_last, out_nbits, out_data);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 5'd16, 1'b0);
    drive(1'b1, 16'hDEAD, 5'd16, 1'b1);
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b101) begin
      $display("FAIL midflush_setup: out_valid=%0b in_ready=%0b busy=%0b, required 1 0 1", out_valid, in_ready, busy);
    end else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_last, out_nbits, out_data, dut.fill_q, in_ready} !== {1'b0, 1'b0, 6'd0, 32'h0, 6'd0, 1'b1}) begin
      $display("FAIL midflush_reset: valid=%0b last=%0b nbits=%0d data=%h fill=%0d in_ready=%0b, required 0 0 0 0 0 1",
               out_valid, out_last, out_nbits, out_data, dut.fill_q, in_ready);
    end else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pack_word();
    test_flush_with_chunk();
    test_last_backpressure();
    test_random_stream();
    test_len_edges();
    test_reset_mid_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
